// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and parity type constants.
// Used by the transmitter today and intended for the receiver as well.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Input FIFO for the UART transmitter, DATA_W x DEPTH, show-ahead read.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: input FIFO, baud prescaler, optional parity and 2 stop bits.
// Frame settings are captured when a word is popped and held for that whole frame.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  P_DATA,
    input  logic               Data_Valid,
    output logic               Data_Ready,
    input  logic               Par_EN,
    input  logic               Par_TYP,
    input  logic               Stop2,
    input  logic [PRESC_W-1:0] Prescale,
    output logic               Tx_out,
    output logic               busy
);

    localparam int BIT_W = $clog2(DATA_W);

    tx_state_t          state;
    tx_state_t          state_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               bit_done;
    logic               advance;
    logic               last_bit;
    logic               tx_d;
    logic [DATA_W-1:0]  fifo_dout;
    logic [DATA_W-1:0]  shift_q;
    logic [PRESC_W-1:0] baud_cnt;
    logic [PRESC_W-1:0] presc_m1_q;
    logic [PRESC_W-1:0] presc_m1_in;
    logic [BIT_W-1:0]   bit_cnt;
    logic               par_en_q;
    logic               stop2_q;
    logic               par_q;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (P_DATA),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign Data_Ready  = ~fifo_full;
    assign push        = Data_Valid & ~fifo_full;
    assign busy        = (state != IDLE) | ~fifo_empty;
    assign bit_done    = (baud_cnt == '0);
    assign last_bit    = (bit_cnt == BIT_W'(DATA_W - 1));
    assign advance     = (state == IDLE) ? ~fifo_empty : bit_done;
    // Every entry into START (from IDLE or back-to-back from a stop bit) consumes a word.
    assign pop         = (state_next == START) && (state != START);
    assign presc_m1_in = (Prescale == '0) ? '0 : Prescale - PRESC_W'(1);

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && last_bit) state_next = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_done) state_next = STOP;
            STOP:    if (bit_done) state_next = stop2_q ? STOP2 : (fifo_empty ? IDLE : START);
            STOP2:   if (bit_done) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Line level for the bit being entered; the shift register moves one step per data bit.
    always_comb begin
        tx_d = 1'b1;
        case (state_next)
            START:   tx_d = 1'b0;
            DATA:    tx_d = (state == DATA) ? shift_q[1] : shift_q[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            Tx_out     <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            presc_m1_q <= '0;
        end else if (pop) begin
            Tx_out     <= tx_d;
            shift_q    <= fifo_dout;
            par_q      <= (Par_TYP == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
            par_en_q   <= Par_EN;
            stop2_q    <= Stop2;
            presc_m1_q <= presc_m1_in;
            baud_cnt   <= presc_m1_in;
            bit_cnt    <= '0;
        end else if (advance) begin
            Tx_out   <= tx_d;
            baud_cnt <= presc_m1_q;
            if (state == DATA) begin
                shift_q <= shift_q >> 1;
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end else if (state != IDLE) begin
            baud_cnt <= baud_cnt - PRESC_W'(1);
        end
    end

endmodule
